// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches one word per request from instruction memory,
// holds it for decode until accepted, then advances pc sequentially or to a branch target.
module fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [3:0]         opcode,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    input  logic               branch_taken,
    output logic [15:0]        issued_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [PC_W-1:0]    pc, pc_next;
    logic [PC_W-1:0]    pc_hold, pc_hold_next;
    logic [INSTR_W-1:0] instr_q, instr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               req_next, valid_next;

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            pc_hold     <= '0;
            instr_q     <= '0;
            cnt         <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pc_hold     <= pc_hold_next;
            instr_q     <= instr_next;
            cnt         <= cnt_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
        end
    end

    // Next-state and datapath update; branch_taken matters only on the handshake
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pc_hold_next = pc_hold;
        instr_next   = instr_q;
        cnt_next     = cnt;
        case (state)
            IDLE: begin
                if (en) state_next = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_next   = imem_rdata;
                    pc_hold_next = pc;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_next    = branch_taken ? instr_q[PC_W-1:0] : pc_hold + PC_W'(1);
                    cnt_next   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
                    state_next = en ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        req_next   = (state_next == FETCH);
        valid_next = (state_next == ISSUE);
    end

    assign imem_addr  = pc;
    assign instr_out  = instr_q;
    assign opcode     = instr_q[INSTR_W-1 -: 4];
    assign pc_out     = pc_hold;
    assign issued_cnt = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [15:0] instr_out;
    logic [7:0]  pc_out;
    logic        branch_taken;
    logic [15:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];

    // Reference model: mode 0 = waiting for enable, 1 = memory request open, 2 = holding an instruction
    int          m_mode;
    logic [7:0]  m_pc;
    logic [7:0]  m_pcout;
    logic [15:0] m_instr;
    logic [15:0] m_cnt;

    fetch_unit #(.PC_W(8), .INSTR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .branch_taken (branch_taken),
        .issued_cnt   (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 8'h00;
        m_pcout = 8'h00;
        m_instr = 16'h0000;
        m_cnt   = 16'h0000;
    endtask

    task automatic check_all();
        chk("imem_req",    32'(imem_req),    32'(m_mode == 1));
        chk("instr_valid", 32'(instr_valid), 32'(m_mode == 2));
        chk("imem_addr",   32'(imem_addr),   32'(m_pc));
        chk("instr_out",   32'(instr_out),   32'(m_instr));
        chk("opcode",      32'(opcode),      32'(m_instr[15:12]));
        chk("pc_out",      32'(pc_out),      32'(m_pcout));
        chk("issued_cnt",  32'(issued_cnt),  32'(m_cnt));
        chk("req_and_valid_exclusive", 32'(imem_req & instr_valid), 32'd0);
    endtask

    // Apply inputs for one cycle, advance the model, check outputs on the next falling edge
    task automatic drive(input logic e, input logic r, input logic b, input logic a);
        logic [15:0] word;
        en           = e;
        instr_ready  = r;
        branch_taken = b;
        imem_ack     = a;
        imem_rdata   = (m_mode == 1) ? mem[m_pc] : 16'($urandom);
        case (m_mode)
            0: if (e) m_mode = 1;
            1: if (a) begin
                word    = mem[m_pc];
                m_instr = word;
                m_pcout = m_pc;
                m_mode  = 2;
            end
            default: if (r) begin
                m_pc   = b ? m_instr[7:0] : 8'(m_pcout + 8'd1);
                m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                m_mode = e ? 1 : 0;
            end
        endcase
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h0123;
        mem[8'h01] = 16'h4037;
        mem[8'h37] = 16'h5000;
        mem[8'h38] = 16'h00FF;
        mem[8'hFF] = 16'hA123;

        rst_n = 1'b0; en = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        instr_ready = 1'b0; branch_taken = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Zero-wait fetch of 0x0123 at address 0
        drive(1, 1, 0, 0);
        chk("first_req", 32'(imem_req), 32'd1);
        drive(1, 1, 0, 1);
        chk("first_valid_pc_out", 32'({instr_valid, opcode, pc_out}), 32'({1'b1, 4'h0, 8'h00}));
        drive(1, 1, 0, 0);
        chk("seq_addr_1", 32'(imem_addr), 32'h01);
        chk("cnt_after_first", 32'(issued_cnt), 32'd1);

        // Taken branch from 0x4037; branch_taken ignored outside handshake
        drive(1, 1, 1, 1);
        drive(1, 1, 1, 0);
        chk("branch_addr", 32'(imem_addr), 32'h37);
        drive(1, 1, 0, 1);

        // Decode stalls for 5 cycles with a stray branch_taken
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 0);
        chk("stall_held", 32'({instr_valid, imem_req, instr_out}), 32'({1'b1, 1'b0, 16'h5000}));
        drive(1, 1, 0, 0);
        chk("not_taken_addr", 32'(imem_addr), 32'h38);

        // Wrap from 0xFF to 0x00
        drive(1, 1, 0, 1);
        drive(1, 1, 1, 0);
        drive(1, 1, 0, 1);
        chk("pc_out_ff", 32'(pc_out), 32'hFF);
        drive(1, 1, 0, 0);
        chk("wrap_addr", 32'(imem_addr), 32'h00);

        // Memory answers after 3 wait cycles, then en=0 at handshake returns to idle
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
        drive(1, 1, 0, 1);
        drive(0, 1, 0, 0);
        chk("idle_after_en_low", 32'({imem_req, instr_valid}), 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1);

        // Asynchronous reset in the middle of a fetch
        drive(1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 0);
        chk("restart_addr", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h00}));
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width; opcode = instr[INSTR_W-1:INSTR_W-4], branch target = instr[PC_W-1:0].
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  run enable; sampled in IDLE and at issue handshake.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  PC_W  read address, equal to pc.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  INSTR_W  fetched instruction word.
REQ-011 instr_valid  output  1  issued instruction available to decode.
REQ-012 instr_ready  input  1  decode stage accepts the instruction.
REQ-013 opcode  output  4  opcode field of the held instruction, fed to ControlUnit.
REQ-014 instr_out  output  INSTR_W  full held instruction.
REQ-015 pc_out  output  PC_W  address the held instruction was fetched from.
REQ-016 branch_taken  input  1  ControlUnit decision for the held opcode, valid while instr_valid=1.
REQ-017 issued_cnt  output  16  count of accepted instructions.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH and ISSUE.
REQ-019 IDLE: when en=1, go to FETCH next cycle; otherwise stay in IDLE.
REQ-020 FETCH: imem_req=1 and imem_addr=pc for every cycle in this state; the address SHALL stay stable until ack.
REQ-021 FETCH with imem_ack=1: latch imem_rdata into the instruction register, latch pc into pc_out, and go to ISSUE next cycle.
REQ-022 imem_ack outside FETCH SHALL be ignored, with no state or data change.
REQ-023 ISSUE: instr_valid=1; opcode, instr_out and pc_out SHALL be held stable until instr_valid and instr_ready are both 1 in the same cycle.
REQ-024 Handshake cycle, next PC: if branch_taken=1, pc <= instr_out[PC_W-1:0]; otherwise pc <= pc_out+1 modulo 2^PC_W (wrap from all-ones to 0).
REQ-025 Handshake cycle, next state: go to FETCH if en=1, else IDLE; instr_valid SHALL drop next cycle.
REQ-026 branch_taken SHALL be sampled only in the handshake cycle and ignored at all other times.
REQ-027 issued_cnt SHALL increment by 1 per handshake and saturate at 16'hFFFF.
REQ-028 imem_req and instr_valid SHALL never both be 1 in the same cycle.
REQ-029 Throughput: with zero-wait memory and instr_ready=1, one instruction SHALL issue every 2 cycles.
REQ-030 en=0 during FETCH or ISSUE SHALL NOT abort the fetch; the held instruction SHALL be issued first.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously, set state=IDLE, pc=0, pc_out=0, instr_out=0, opcode=0, imem_req=0, imem_addr=0, instr_valid=0, issued_cnt=0.
REQ-032 Reset mid-FETCH or mid-ISSUE SHALL abandon the outstanding request and the held instruction; an ack arriving in the cycle after reset release while in IDLE SHALL be ignored.
REQ-033 After reset release, the first fetch address SHALL be 0.

Verification
REQ-034 Reset, en=1, zero-wait memory returning 16'h0123 at addr 0, instr_ready=1 -> imem_req at cycle 1, instr_valid at cycle 2 with opcode=0 and pc_out=0; next imem_addr=1; issued_cnt=1.
REQ-035 ISSUE with instr=16'h4037 and branch_taken=1 at handshake -> next imem_addr=8'h37; with branch_taken=0 -> pc_out+1.
REQ-036 instr_ready held 0 for 5 cycles -> instr_valid, opcode, instr_out and pc_out stay constant, imem_req stays 0, pc unchanged.
REQ-037 pc_out=8'hFF, non-branch handshake -> next imem_addr=8'h00.
REQ-038 imem_ack delayed 3 cycles -> imem_addr stable and imem_req=1 throughout; spurious ack while in IDLE -> no change.
REQ-039 rst_n pulsed low mid-FETCH -> all outputs 0 immediately; restart fetches addr 0; en=0 at handshake -> return to IDLE with no further imem_req.
